display_source_arbiter: RTL and testbench

- Parametrised successor to the clock's fixed five-way display multiplexer.
- Selects one of NUM_SRC digit sources (timer, alarm, set, stopwatch, clock, ...) by fixed priority and drives NUM_DIGITS registered digit outputs to the 7-segment decoders.
- Adds two sequential features: a blanking interval on every source change, and blinking of the digits being edited.

---
 rtl/display_source_arbiter.sv | 113 +++++++++++
 tb/tb_display_source_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/display_source_arbiter.sv
// Fixed-priority display source selector with change blanking and edit blinking.
// Drives registered digits, per-digit blanks and the selected index to the 7-segment decoders.
module display_source_arbiter #(
    parameter int unsigned NUM_SRC      = 5,
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned DIGIT_W      = 4,
    parameter int unsigned BLINK_HALF   = 25000000,
    parameter int unsigned SWITCH_BLANK = 5000000,
    localparam int unsigned SEL_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                            CLK,
    input  logic                            RESET,
    input  logic [NUM_SRC-1:0]              SRC_REQ,
    input  logic [NUM_SRC*NUM_DIGITS*DIGIT_W-1:0] SRC_DATA,
    input  logic                            EDIT_EN,
    input  logic [NUM_DIGITS-1:0]           EDIT_MASK,
    output logic [NUM_DIGITS*DIGIT_W-1:0]   OUT_DATA,
    output logic [NUM_DIGITS-1:0]           OUT_BLANK,
    output logic [SEL_W-1:0]                OUT_SEL,
    output logic                            OUT_CHANGING
);

    localparam int unsigned SLICE_W = NUM_DIGITS * DIGIT_W;
    localparam int unsigned BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int unsigned CHG_W   = (SWITCH_BLANK > 1) ? $clog2(SWITCH_BLANK) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST  = BLINK_W'(BLINK_HALF - 1);
    localparam logic [CHG_W-1:0]   CHG_RELOAD  = (SWITCH_BLANK != 0) ? CHG_W'(SWITCH_BLANK - 1) : '0;
    localparam logic [SEL_W-1:0]   DEFAULT_SEL = SEL_W'(NUM_SRC - 1);

    typedef enum logic {SHOW, CHANGE} state_t;

    state_t                 state, state_n;
    logic [SEL_W-1:0]       winner;
    logic [SLICE_W-1:0]     win_data;
    logic                   sel_change;
    logic [CHG_W-1:0]       chg_cnt, chg_cnt_n;
    logic [BLINK_W-1:0]     blink_cnt, blink_cnt_n;
    logic                   phase, phase_n;
    logic [NUM_DIGITS-1:0]  blank_n;

    // Lowest requesting index wins; scanning downward lets the lowest overwrite.
    always_comb begin
        winner   = DEFAULT_SEL;
        win_data = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (SRC_REQ[i]) winner = SEL_W'(i);
        end
        for (int s = 0; s < int'(NUM_SRC); s++) begin
            if (winner == SEL_W'(s)) win_data = SRC_DATA[s*SLICE_W +: SLICE_W];
        end
    end

    // Next-state, blanking countdown, blink counter and blank mask.
    always_comb begin
        state_n     = state;
        chg_cnt_n   = chg_cnt;
        blink_cnt_n = blink_cnt;
        phase_n     = phase;
        sel_change  = (winner != OUT_SEL);

        case (state)
            SHOW: begin
                if (sel_change && (SWITCH_BLANK != 0)) begin
                    state_n   = CHANGE;
                    chg_cnt_n = CHG_RELOAD;
                end
            end
            CHANGE: begin
                if (sel_change)           chg_cnt_n = CHG_RELOAD;
                else if (chg_cnt == '0)   state_n   = SHOW;
                else                      chg_cnt_n = chg_cnt - CHG_W'(1);
            end
            default: state_n = SHOW;
        endcase

        // A selection change restarts the blink cycle in the visible phase.
        if (sel_change) begin
            blink_cnt_n = '0;
            phase_n     = 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt_n = '0;
            phase_n     = ~phase;
        end else begin
            blink_cnt_n = blink_cnt + BLINK_W'(1);
        end

        blank_n = {NUM_DIGITS{state_n == CHANGE}}
                | (EDIT_MASK & {NUM_DIGITS{EDIT_EN & phase_n}});
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= SHOW;
            chg_cnt      <= '0;
            blink_cnt    <= '0;
            phase        <= 1'b0;
            OUT_SEL      <= DEFAULT_SEL;
            OUT_DATA     <= '0;
            OUT_BLANK    <= '1;
            OUT_CHANGING <= 1'b0;
        end else begin
            state        <= state_n;
            chg_cnt      <= chg_cnt_n;
            blink_cnt    <= blink_cnt_n;
            phase        <= phase_n;
            OUT_SEL      <= winner;
            OUT_DATA     <= win_data;
            OUT_BLANK    <= blank_n;
            OUT_CHANGING <= (state_n == CHANGE);
        end
    end

endmodule

// File: tb/tb_display_source_arbiter.sv
// Bench for display_source_arbiter: directed scenarios plus randomized traffic,
// checked against a time-based model (blanking window and blink phase from edge counts).
module tb_display_source_arbiter;

    localparam int NS = 5;
    localparam int ND = 8;
    localparam int DW = 4;
    localparam int BH = 4;
    localparam int SB = 3;

    logic                 CLK = 1'b0;
    logic                 RESET;
    logic [NS-1:0]        SRC_REQ;
    logic [NS*ND*DW-1:0]  SRC_DATA;
    logic                 EDIT_EN;
    logic [ND-1:0]        EDIT_MASK;
    logic [ND*DW-1:0]     OUT_DATA;
    logic [ND-1:0]        OUT_BLANK;
    logic [2:0]           OUT_SEL;
    logic                 OUT_CHANGING;

    display_source_arbiter #(
        .NUM_SRC(NS), .NUM_DIGITS(ND), .DIGIT_W(DW),
        .BLINK_HALF(BH), .SWITCH_BLANK(SB)
    ) dut (
        .CLK(CLK), .RESET(RESET), .SRC_REQ(SRC_REQ), .SRC_DATA(SRC_DATA),
        .EDIT_EN(EDIT_EN), .EDIT_MASK(EDIT_MASK), .OUT_DATA(OUT_DATA),
        .OUT_BLANK(OUT_BLANK), .OUT_SEL(OUT_SEL), .OUT_CHANGING(OUT_CHANGING)
    );

    always #5 CLK = ~CLK;

    logic [3:0]  mem [NS][ND];
    int          edge_no   = 0;
    int          last_chg  = -1000;
    int          origin    = 0;
    int          m_sel     = NS - 1;
    logic [31:0] m_data    = '0;
    logic [7:0]  m_blank   = '1;
    logic        m_chg     = 1'b0;
    int          vectors     = 0;
    int          miscompares = 0;

    function automatic int winner_of(input logic [NS-1:0] r);
        for (int i = 0; i < NS; i++) if (r[i]) return i;
        return NS - 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model: CHANGE lasts SB edges from the last selection change; blink phase flips every BH edges
    // measured from the last change or reset.
    task automatic model_edge();
        int w;
        int ph;
        if (RESET) begin
            m_sel    = NS - 1;
            m_data   = '0;
            m_blank  = '1;
            m_chg    = 1'b0;
            origin   = edge_no;
            last_chg = -1000;
        end else begin
            w = winner_of(SRC_REQ);
            if (w != m_sel) begin
                last_chg = edge_no;
                origin   = edge_no;
            end
            m_sel = w;
            m_chg = (SB > 0) && (edge_no - last_chg < SB);
            ph    = ((edge_no - origin) / BH) % 2;
            m_blank = m_chg ? 8'hFF : ((EDIT_EN && ph == 1) ? EDIT_MASK : 8'h00);
            for (int d = 0; d < ND; d++) m_data[d*DW +: DW] = mem[w][d];
        end
    endtask

    task automatic step();
        for (int s = 0; s < NS; s++)
            for (int d = 0; d < ND; d++)
                SRC_DATA[(s*ND+d)*DW +: DW] = mem[s][d];
        @(posedge CLK);
        edge_no++;
        model_edge();
        #1;
        check("sel",      32'(OUT_SEL),      32'(m_sel));
        check("data",     OUT_DATA,          m_data);
        check("blank",    32'(OUT_BLANK),    32'(m_blank));
        check("changing", 32'(OUT_CHANGING), 32'(m_chg));
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        for (int s = 0; s < NS; s++)
            for (int d = 0; d < ND; d++)
                mem[s][d] = 4'((s + d) % 10);
        RESET = 1'b1; SRC_REQ = 5'b01010; EDIT_EN = 1'b0; EDIT_MASK = 8'h00; SRC_DATA = '0;

        // Reset held two cycles
        steps(2);
        check("rst_sel",   32'(OUT_SEL), 32'd4);
        check("rst_data",  OUT_DATA, 32'h0);
        check("rst_blank", 32'(OUT_BLANK), 32'hFF);
        check("rst_chg",   32'(OUT_CHANGING), 32'd0);
        RESET = 1'b0;
        step();
        check("rel_sel", 32'(OUT_SEL), 32'd1);
        check("rel_chg", 32'(OUT_CHANGING), 32'd1);

        // Priority
        SRC_REQ = 5'b11000; steps(5);
        check("prio_sel3", 32'(OUT_SEL), 32'd3);
        SRC_REQ = 5'b11001; step();
        check("prio_sel0", 32'(OUT_SEL), 32'd0);
        check("prio_data0", OUT_DATA, 32'h76543210);

        // Change blanking, single switch 4->2
        SRC_REQ = 5'b00000; steps(5);
        SRC_REQ = 5'b00100;
        step(); check("blank_n0", 32'(OUT_BLANK), 32'hFF);
        step(); check("blank_n1", 32'(OUT_BLANK), 32'hFF);
        step(); check("blank_n2", 32'(OUT_BLANK), 32'hFF);
        step(); check("blank_n3", 32'(OUT_BLANK), 32'h00);

        // Second switch one edge later extends the window
        SRC_REQ = 5'b00000; steps(5);
        SRC_REQ = 5'b00100; step();
        SRC_REQ = 5'b01000; step();
        step(); step();
        check("ext_n3", 32'(OUT_BLANK), 32'hFF);
        step();
        check("ext_n4", 32'(OUT_BLANK), 32'h00);

        // Edit blink on source 2
        SRC_REQ = 5'b00000; steps(5);
        EDIT_EN = 1'b1; EDIT_MASK = 8'h0C; SRC_REQ = 5'b00100;
        steps(4); check("blink_vis", 32'(OUT_BLANK), 32'h00);
        step();   check("blink_dark", 32'(OUT_BLANK), 32'h0C);
        steps(3); check("blink_dark_end", 32'(OUT_BLANK), 32'h0C);
        step();   check("blink_vis2", 32'(OUT_BLANK), 32'h00);
        steps(5); check("blink_dark2", 32'(OUT_BLANK), 32'h0C);
        SRC_REQ = 5'b00000;
        steps(4); check("blink_phase_rst", 32'(OUT_BLANK), 32'h00);
        steps(6);

        // Data tracking while selected
        EDIT_EN = 1'b0; steps(2);
        mem[4][3] = 4'd9;
        step();
        check("track_d3", 32'(OUT_DATA[15:12]), 32'd9);
        check("track_blank", 32'(OUT_BLANK), 32'h00);

        // Reset in the middle of CHANGE
        SRC_REQ = 5'b00100; steps(2);
        RESET = 1'b1; step();
        check("midrst_sel", 32'(OUT_SEL), 32'd4);
        check("midrst_blank", 32'(OUT_BLANK), 32'hFF);
        check("midrst_chg", 32'(OUT_CHANGING), 32'd0);
        RESET = 1'b0; SRC_REQ = 5'b00000; EDIT_EN = 1'b1; EDIT_MASK = 8'hFF;
        steps(3); check("midrst_vis", 32'(OUT_BLANK), 32'h00);
        step();   check("midrst_dark", 32'(OUT_BLANK), 32'hFF);

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            RESET = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 7) == 0) SRC_REQ = 5'($urandom);
            if ($urandom_range(0, 15) == 0) EDIT_EN = ~EDIT_EN;
            if ($urandom_range(0, 11) == 0) EDIT_MASK = 8'($urandom);
            if ($urandom_range(0, 3) == 0)
                mem[$urandom_range(0, NS-1)][$urandom_range(0, ND-1)] = 4'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
